// File: rtl/instruction_decoder.sv
// instruction_decoder: turns a stream of ASCII light-grid puzzle lines into packed instruction words.
// Define INSTRUCTION_DECODER_STATS_EN to enable the saturating instr_count/drop_count counters.
module instruction_decoder #(
  parameter int COORD_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inbound_valid,
  input  logic [7:0]               inbound_data,
  output logic                     wr_valid,
  output logic [4*COORD_WIDTH+3:0] wr_data,
  output logic                     done,
  output logic                     parse_error,
  output logic [15:0]              instr_count,
  output logic [15:0]              drop_count
);
  localparam int INSTRUCTION_WIDTH = 4*COORD_WIDTH+4;

  typedef enum logic [2:0] {LINE_START, KEYWORD, NUMBER, GAP, FLUSH, DONE} state_t;

  state_t                       state_reg;
  logic [COORD_WIDTH-1:0]       acc_reg;
  logic [COORD_WIDTH-1:0]       field_reg [4];
  logic [2:0]                   idx_reg;
  logic [1:0]                   op_reg;
  logic                         bad_reg;
  logic                         hold_valid_reg;
  // The hold keeps everything but the last flag, which is decided at emission time.
  logic [INSTRUCTION_WIDTH-2:0] hold_reg;

  logic                         is_digit;
  logic                         is_letter;
  logic                         is_nl;
  logic                         is_nul;
  logic                         closing;
  logic                         line_ok;
  logic [1:0]                   letter_op;
  logic [COORD_WIDTH-1:0]       digit_val;
  logic [COORD_WIDTH-1:0]       acc_next;
  logic [3:0]                   fields_total;
  logic [INSTRUCTION_WIDTH-2:0] line_word;

  always_comb begin
    is_digit  = (inbound_data >= 8'h30) && (inbound_data <= 8'h39);
    is_letter = ((inbound_data >= 8'h61) && (inbound_data <= 8'h7A)) ||
                ((inbound_data >= 8'h41) && (inbound_data <= 8'h5A));
    is_nl     = (inbound_data == 8'h0A);
    is_nul    = (inbound_data == 8'h00);
    digit_val = COORD_WIDTH'(inbound_data - 8'h30);
    acc_next  = COORD_WIDTH'(acc_reg * 10 + digit_val);
    case (inbound_data)
      8'h66:   letter_op = 2'b00;
      8'h6E:   letter_op = 2'b01;
      8'h65:   letter_op = 2'b10;
      default: letter_op = 2'b11;
    endcase
    // A number still being accumulated counts as the final field when the line ends.
    closing      = (state_reg == NUMBER);
    fields_total = {1'b0, idx_reg} + {3'b000, closing};
    line_ok      = !bad_reg && (op_reg != 2'b11) && (fields_total == 4'd4);
    line_word    = {1'b1, op_reg, field_reg[0], field_reg[1], field_reg[2],
                    closing ? acc_reg : field_reg[3]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= LINE_START;
      acc_reg        <= '0;
      idx_reg        <= '0;
      op_reg         <= 2'b11;
      bad_reg        <= 1'b0;
      hold_valid_reg <= 1'b0;
      hold_reg       <= '0;
      for (int i = 0; i < 4; i++) field_reg[i] <= '0;
      wr_valid       <= 1'b0;
      wr_data        <= '0;
      done           <= 1'b0;
      parse_error    <= 1'b0;
    end else begin
      wr_valid    <= 1'b0;
      parse_error <= 1'b0;
      if (state_reg == FLUSH) begin
        wr_valid       <= 1'b1;
        wr_data        <= {1'b1, hold_reg};
        hold_valid_reg <= 1'b0;
        done           <= 1'b1;
        state_reg      <= DONE;
      end else if (state_reg != DONE && inbound_valid && inbound_data != 8'h0D) begin
        if (is_nul || (is_nl && state_reg != LINE_START)) begin
          if (line_ok) begin
            hold_reg       <= line_word;
            hold_valid_reg <= 1'b1;
            if (hold_valid_reg) begin
              wr_valid <= 1'b1;
              wr_data  <= {1'b0, hold_reg};
            end
          end else if (state_reg != LINE_START) begin
            parse_error <= 1'b1;
          end
          acc_reg <= '0;
          idx_reg <= '0;
          op_reg  <= 2'b11;
          bad_reg <= 1'b0;
          for (int i = 0; i < 4; i++) field_reg[i] <= '0;
          if (is_nl) begin
            state_reg <= LINE_START;
          end else if (line_ok || hold_valid_reg) begin
            state_reg <= FLUSH;
          end else begin
            state_reg <= DONE;
            done      <= 1'b1;
          end
        end else begin
          case (state_reg)
            LINE_START: if (is_letter) begin
              op_reg    <= letter_op;
              state_reg <= KEYWORD;
            end
            KEYWORD: if (is_digit) begin
              acc_reg   <= digit_val;
              state_reg <= NUMBER;
            end else if (is_letter) begin
              op_reg <= letter_op;
            end
            NUMBER: if (is_digit) begin
              acc_reg <= acc_next;
            end else begin
              if (idx_reg < 3'd4) begin
                field_reg[idx_reg[1:0]] <= acc_reg;
                idx_reg                 <= idx_reg + 3'd1;
              end else begin
                bad_reg <= 1'b1;
              end
              state_reg <= GAP;
            end
            GAP: if (is_digit) begin
              acc_reg   <= digit_val;
              state_reg <= NUMBER;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef INSTRUCTION_DECODER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= '0;
      drop_count  <= '0;
    end else begin
      if (wr_valid && instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
      if (parse_error && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign instr_count = '0;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// Testbench for instruction_decoder: directed scenarios plus randomized line streams vs a line-level model.
module tb_instruction_decoder;
  localparam int CW = 10;
  localparam int W  = 4*CW+4;
`ifdef INSTRUCTION_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inbound_valid = 1'b0;
  logic [7:0]  inbound_data = 8'h00;
  logic        wr_valid;
  logic [W-1:0] wr_data;
  logic        done;
  logic        parse_error;
  logic [15:0] instr_count;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_cyc = 0;
  int base_w = 0, base_pe = 0, base_viol = 0;

  instruction_decoder #(.COORD_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .inbound_valid(inbound_valid), .inbound_data(inbound_data),
    .wr_valid(wr_valid), .wr_data(wr_data), .done(done), .parse_error(parse_error),
    .instr_count(instr_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse with the cycle it was seen in.
  logic [W-1:0] obs_w[$];
  int obs_c[$];
  int pe_total = 0, viol_total = 0, done_cyc = -1, pe_cyc = -1;
  logic prev_v = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    if (wr_valid) begin
      obs_w.push_back(wr_data);
      obs_c.push_back(cyc);
    end
    if (wr_valid && prev_v && !wr_data[W-1]) viol_total <= viol_total + 1;
    if (parse_error) begin
      pe_total <= pe_total + 1;
      pe_cyc   <= cyc;
    end
    if (done && !prev_done) done_cyc <= cyc;
    prev_v    <= wr_valid;
    prev_done <= done;
  end

  // Reference model: evaluates whole lines from the text rules.
  logic [W-1:0] exp_q[$];
  int exp_drops;

  function automatic logic [W-1:0] mkw(input logic last, input logic [1:0] op,
                                       input int a, input int b, input int c, input int d);
    return {last, 1'b1, op, a[CW-1:0], b[CW-1:0], c[CW-1:0], d[CW-1:0]};
  endfunction

  task automatic eval_line(input string ln);
    int fd = -1;
    int op = 3;
    int vals[$];
    int cur = -1;
    bit has_letter = 0;
    byte c;
    for (int i = 0; i < ln.len(); i++) begin
      c = ln[i];
      if (c >= 8'h30 && c <= 8'h39) begin fd = i; break; end
      if ((c >= 8'h61 && c <= 8'h7A) || (c >= 8'h41 && c <= 8'h5A)) begin
        has_letter = 1;
        op = (c == 8'h66) ? 0 : (c == 8'h6E) ? 1 : (c == 8'h65) ? 2 : 3;
      end
    end
    if (fd < 0) begin
      if (has_letter) exp_drops++;
      return;
    end
    for (int i = fd; i < ln.len(); i++) begin
      c = ln[i];
      if (c >= 8'h30 && c <= 8'h39) cur = ((cur < 0 ? 0 : cur) * 10 + (c - 8'h30)) % (1 << CW);
      else if (cur >= 0) begin vals.push_back(cur); cur = -1; end
    end
    if (cur >= 0) vals.push_back(cur);
    if (vals.size() == 4 && op != 3) exp_q.push_back(mkw(1'b0, 2'(op), vals[0], vals[1], vals[2], vals[3]));
    else exp_drops++;
  endtask

  task automatic run_model(input string s);
    string ln = "";
    logic [W-1:0] tmp;
    exp_q.delete();
    exp_drops = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A) begin eval_line(ln); ln = ""; end
      else if (s[i] != 8'h0D) ln = {ln, string'(s[i])};
    end
    eval_line(ln);
    if (exp_q.size() > 0) begin
      tmp = exp_q.pop_back();
      tmp[W-1] = 1'b1;
      exp_q.push_back(tmp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    inbound_valid = 1'b1;
    inbound_data  = b;
    @(posedge clk);
    #1;
    last_cyc      = cyc;
    inbound_valid = 1'b0;
    inbound_data  = 8'h00;
  endtask

  task automatic send_str(input string s, input bit idles);
    for (int i = 0; i < s.len(); i++) begin
      if (idles && ($urandom % 4 == 0)) begin
        @(negedge clk);
        inbound_valid = 1'b0;
        inbound_data  = 8'($urandom);
        @(posedge clk);
        #1;
        inbound_data = 8'h00;
      end
      send_byte(s[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    inbound_valid = 1'b0;
    @(posedge clk);
    #1;
    base_w = obs_w.size(); base_pe = pe_total; base_viol = viol_total;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 10 && !done; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (parse_error !== 1'b0) begin errors++; $display("FAIL reset_parse_error got=%b exp=0", parse_error); end
    checks++; if (instr_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", instr_count, drop_count); end
    $display("reset: outputs idle");
  endtask

  task automatic test_single();
    int z, n;
    logic [W-1:0] w;
    do_reset();
    send_str("turn on 0,0 through 999,999\n", 0);
    send_byte(8'h00); z = last_cyc;
    wait_done();
    n = obs_w.size() - base_w;
    w = (n > 0) ? obs_w[base_w] : '0;
    checks++; if (n != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", n); end
    checks++; if (w !== mkw(1'b1, 2'b01, 0, 0, 999, 999)) begin
      errors++; $display("FAIL single_word got=%h exp=%h", w, mkw(1'b1, 2'b01, 0, 0, 999, 999)); end
    checks++; if (n > 0 && obs_c[base_w] != z + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", obs_c[base_w], z + 1); end
    checks++; if (done !== 1'b1 || done_cyc != z + 1) begin errors++; $display("FAIL single_done got=%b@%0d exp=1@%0d", done, done_cyc, z + 1); end
    checks++; if (pe_total - base_pe != 0) begin errors++; $display("FAIL single_pe got=%0d exp=0", pe_total - base_pe); end
    checks++; if (instr_count !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL single_instr_count got=%0d exp=%0d", instr_count, STATS ? 1 : 0); end
    $display("single: %0d word(s) w=%h", n, w);
  endtask

  task automatic test_two_lines();
    int z, nl2, n;
    logic [W-1:0] w0, w1;
    do_reset();
    send_str("toggle 1,2 through 3,4\nturn off 5,6 through 7,8\n", 0); nl2 = last_cyc;
    send_byte(8'h00); z = last_cyc;
    wait_done();
    n = obs_w.size() - base_w;
    w0 = (n > 0) ? obs_w[base_w] : '0;
    w1 = (n > 1) ? obs_w[base_w+1] : '0;
    checks++; if (n != 2) begin errors++; $display("FAIL two_count got=%0d exp=2", n); end
    checks++; if (w0 !== mkw(1'b0, 2'b10, 1, 2, 3, 4)) begin errors++; $display("FAIL two_word0 got=%h exp=%h", w0, mkw(1'b0, 2'b10, 1, 2, 3, 4)); end
    checks++; if (n > 0 && obs_c[base_w] != nl2) begin errors++; $display("FAIL two_latency0 got=%0d exp=%0d", obs_c[base_w], nl2); end
    checks++; if (w1 !== mkw(1'b1, 2'b00, 5, 6, 7, 8)) begin errors++; $display("FAIL two_word1 got=%h exp=%h", w1, mkw(1'b1, 2'b00, 5, 6, 7, 8)); end
    checks++; if (n > 1 && obs_c[base_w+1] != z + 1) begin errors++; $display("FAIL two_latency1 got=%0d exp=%0d", obs_c[base_w+1], z + 1); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL two_done got=%b exp=1", done); end
    $display("two_lines: %0d word(s) w0=%h w1=%h", n, w0, w1);
  endtask

  task automatic test_drop();
    int z, nl, n;
    do_reset();
    send_str("turn on 1,2 through 3\n", 0); nl = last_cyc;
    send_byte(8'h00); z = last_cyc;
    wait_done();
    n = obs_w.size() - base_w;
    checks++; if (n != 0) begin errors++; $display("FAIL drop_count_words got=%0d exp=0", n); end
    checks++; if (pe_total - base_pe != 1 || pe_cyc != nl) begin
      errors++; $display("FAIL drop_parse_error got=%0d@%0d exp=1@%0d", pe_total - base_pe, pe_cyc, nl); end
    checks++; if (done !== 1'b1 || done_cyc != z) begin errors++; $display("FAIL drop_done got=%b@%0d exp=1@%0d", done, done_cyc, z); end
    checks++; if (drop_count !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL drop_drop_count got=%0d exp=%0d", drop_count, STATS ? 1 : 0); end
    $display("drop: words=%0d parse_errors=%0d", n, pe_total - base_pe);
  endtask

  task automatic test_back_to_back();
    int z, n;
    logic [W-1:0] w0, w1;
    do_reset();
    send_str("turn on 1,1 through 2,2\r\ntoggle 3,3 through 4,4", 0);
    send_byte(8'h00); z = last_cyc;
    wait_done();
    n = obs_w.size() - base_w;
    w0 = (n > 0) ? obs_w[base_w] : '0;
    w1 = (n > 1) ? obs_w[base_w+1] : '0;
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", n); end
    checks++; if (w0 !== mkw(1'b0, 2'b01, 1, 1, 2, 2) || (n > 0 && obs_c[base_w] != z)) begin
      errors++; $display("FAIL b2b_word0 got=%h exp=%h", w0, mkw(1'b0, 2'b01, 1, 1, 2, 2)); end
    checks++; if (w1 !== mkw(1'b1, 2'b10, 3, 3, 4, 4) || (n > 1 && obs_c[base_w+1] != z + 1)) begin
      errors++; $display("FAIL b2b_word1 got=%h exp=%h", w1, mkw(1'b1, 2'b10, 3, 3, 4, 4)); end
    checks++; if (instr_count !== (STATS ? 16'd2 : 16'd0)) begin errors++; $display("FAIL b2b_instr_count got=%0d exp=%0d", instr_count, STATS ? 2 : 0); end
    checks++; if (viol_total - base_viol != 0) begin errors++; $display("FAIL b2b_consecutive got=%0d exp=0", viol_total - base_viol); end
    $display("back_to_back: %0d word(s) w0=%h w1=%h", n, w0, w1);
  endtask

  task automatic test_reset_midline();
    int n, b;
    logic [W-1:0] w;
    do_reset();
    send_str("turn on 2,2 through 2,2\ntoggle 9,9 thr", 0);
    do_reset();
    send_str("turn on 1,1 through 1,1\n", 0);
    send_byte(8'h00);
    wait_done();
    n = obs_w.size() - base_w;
    w = (n > 0) ? obs_w[base_w] : '0;
    checks++; if (n != 1) begin errors++; $display("FAIL midreset_count got=%0d exp=1", n); end
    checks++; if (w !== mkw(1'b1, 2'b01, 1, 1, 1, 1)) begin errors++; $display("FAIL midreset_word got=%h exp=%h", w, mkw(1'b1, 2'b01, 1, 1, 1, 1)); end
    // Reset landing on the FLUSH cycle must swallow the held word.
    do_reset();
    send_str("toggle 5,5 through 6,6\n", 0);
    send_byte(8'h00);
    reset = 1'b1;
    b = obs_w.size();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (obs_w.size() != b || done !== 1'b0) begin
      errors++; $display("FAIL flushreset got=%0d words done=%b exp=0 words done=0", obs_w.size() - b, done); end
    $display("reset_midline: %0d word(s) w=%h, flush-reset words=%0d", n, w, obs_w.size() - b);
  endtask

  task automatic test_random(input int streams);
    string kws[5];
    kws[0] = "turn on"; kws[1] = "turn off"; kws[2] = "toggle"; kws[3] = "flip"; kws[4] = "turn on";
    for (int t = 0; t < streams; t++) begin
      string s = "";
      int nl = $urandom_range(1, 5);
      int n, nf;
      logic [W-1:0] ow;
      for (int l = 0; l < nl; l++) begin
        if ($urandom % 6 == 0) s = {s, "\n"};
        nf = ($urandom % 10 < 7) ? 4 : $urandom_range(3, 5);
        s = {s, kws[$urandom % 5], " "};
        for (int k = 0; k < nf; k++) begin
          s = {s, $sformatf("%0d", $urandom_range(0, 1200))};
          if (k < nf - 1) s = {s, (k == 1) ? " through " : ","};
        end
        if (l < nl - 1 || ($urandom % 2 == 0)) s = {s, ($urandom % 2 == 0) ? "\n" : "\r\n"};
      end
      run_model(s);
      do_reset();
      send_str(s, 1);
      send_byte(8'h00);
      wait_done();
      n = obs_w.size() - base_w;
      checks++; if (n != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", t, n, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        ow = (i < n) ? obs_w[base_w+i] : '0;
        checks++; if (ow !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word%0d got=%h exp=%h", t, i, ow, exp_q[i]); end
      end
      checks++; if (pe_total - base_pe != exp_drops) begin errors++; $display("FAIL rand%0d_drops got=%0d exp=%0d", t, pe_total - base_pe, exp_drops); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rand%0d_done got=%b exp=1", t, done); end
      checks++; if (viol_total - base_viol != 0) begin errors++; $display("FAIL rand%0d_consecutive got=%0d exp=0", t, viol_total - base_viol); end
      checks++; if (instr_count !== (STATS ? 16'(exp_q.size()) : 16'd0) || drop_count !== (STATS ? 16'(exp_drops) : 16'd0)) begin
        errors++; $display("FAIL rand%0d_stats got=%0d/%0d", t, instr_count, drop_count); end
      $display("random %0d: lines=%0d words=%0d drops=%0d", t, nl, n, pe_total - base_pe);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_lines();
    test_drop();
    test_back_to_back();
    test_reset_midline();
    test_random(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_decoder.md
INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 Parameter COORD_WIDTH, 10, bit width of each coordinate field; INSTRUCTION_WIDTH SHALL be the localparam 4*COORD_WIDTH+4.
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inbound_valid  input  1  qualifies inbound_data; one byte accepted per asserted cycle, no backpressure.
REQ-005 inbound_data  input  8  ASCII puzzle byte.
REQ-006 wr_valid  output  1  single-cycle strobe, one instruction word per pulse; no ready exists.
REQ-007 wr_data  output  INSTRUCTION_WIDTH  instruction word, valid only while wr_valid=1.
REQ-008 done  output  1  level; high once the final instruction has been emitted.
REQ-009 parse_error  output  1  single-cycle pulse when a line is dropped.
REQ-010 instr_count  output  16  emitted instruction count (see Configuration).
REQ-011 drop_count  output  16  dropped line count (see Configuration).

Function
REQ-012 wr_data layout SHALL be: [W-1] last, [W-2] valid (always 1 when emitted), [W-3:W-4] opcode, then x0, y0, x1, y1 fields of COORD_WIDTH each, MSB to LSB.
REQ-013 Opcode SHALL be 00 turn off, 01 turn on, 10 toggle; 11 never emitted.
REQ-014 Opcode SHALL be taken from the last lowercase letter seen before the first digit of a line: 'f'->00, 'n'->01, 'e'->10; any other letter marks the line malformed.
REQ-015 FSM states SHALL be LINE_START, KEYWORD, NUMBER, GAP, FLUSH, DONE.
REQ-016 LINE_START: letter->KEYWORD; 0x0A, 0x0D, space ignored; 0x00->terminator handling (REQ-022).
REQ-017 KEYWORD: digit->NUMBER with accumulator loaded with the digit value; letters and space stay in KEYWORD.
REQ-018 NUMBER: digit SHALL update acc = acc*10 + digit, truncated modulo 2^COORD_WIDTH; ',' or space SHALL store acc in field[idx], idx+1, ->GAP.
REQ-019 GAP: digit->NUMBER; letters ',' and space ignored; more than 4 fields marks the line malformed.
REQ-020 0x0A in NUMBER or GAP SHALL close any open number, then complete the line if exactly 4 fields and the opcode is valid, else drop it with parse_error=1 the following cycle; next state LINE_START.
REQ-021 A completed line SHALL load a one-deep hold register; if the hold was occupied, the previous word SHALL be emitted with last=0 on wr_valid in the cycle after the 0x0A byte.
REQ-022 On 0x00: a complete pending line SHALL be treated as REQ-021 and state ->FLUSH; FLUSH SHALL emit the hold with last=1 the next cycle and ->DONE. An empty hold SHALL go directly to DONE with no emission.
REQ-023 0x0D SHALL be ignored in every state; bytes with inbound_valid=0 SHALL have no effect.
REQ-024 DONE SHALL ignore all input; done=1 from the cycle the last word is emitted, or from the cycle after 0x00 when nothing is emitted.
REQ-025 wr_valid SHALL never assert on two consecutive cycles except for the FLUSH pair in REQ-022.

Reset
REQ-026 Reset SHALL force state LINE_START, clear hold/fields/idx/acc, and drive wr_valid=0, wr_data=0, done=0, parse_error=0, instr_count=0, drop_count=0.
REQ-027 Reset mid-line or in FLUSH SHALL discard all pending data with no emission.

Configuration
REQ-028 Macro INSTRUCTION_DECODER_STATS_EN defined: instr_count SHALL count wr_valid pulses and drop_count SHALL count parse_error pulses, both saturating at 0xFFFF.
REQ-029 Without the macro: both ports SHALL be tied to 0 with no counter logic and an unchanged port list.

Verification
REQ-030 "turn on 0,0 through 999,999\n" then 0x00 -> one pulse, last=1, op=01, x0=0, y0=0, x1=999, y1=999; done=1.
REQ-031 "toggle 1,2 through 3,4\n" then "turn off 5,6 through 7,8\n" then 0x00 -> pulse op=10 (1,2,3,4) last=0 after the 2nd 0x0A; then op=00 (5,6,7,8) last=1.
REQ-032 "turn on 1,2 through 3\n" then 0x00 -> parse_error pulse, drop_count=1 when enabled, no wr_valid, done=1.
REQ-033 "turn on 1,1 through 2,2\r\n" then "toggle 3,3 through 4,4" then 0x00 with no newline -> two wr_valid pulses on consecutive cycles, 2nd with last=1, instr_count=2.
REQ-034 Reset asserted after "toggle 9,9 thr" -> no output; then "turn on 1,1 through 1,1\n" then 0x00 -> one word op=01 (1,1,1,1) last=1.
